// File: rtl/tempo_pkg.sv
// tempo_pkg: shared state encoding, difficulty codes and default timing constants for the tempo sequencer.
package tempo_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COUNTIN = 3'd1,
        RUN     = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] DIFF_INSANE  = 2'b00;
    localparam logic [1:0] DIFF_NORMAL  = 2'b01;
    localparam logic [1:0] DIFF_SLOWER  = 2'b10;
    localparam logic [1:0] DIFF_SLOWEST = 2'b11;

    localparam int DEF_P0 = 8_000_000;
    localparam int DEF_P1 = 25_000_000;
    localparam int DEF_P2 = 30_000_000;
    localparam int DEF_P3 = 40_000_000;

    localparam int METRO_W = 16;
endpackage

// File: rtl/tick_counter.sv
// tick_counter: loadable countdown with a zero flag, shared timebase for count-in and beats.
module tick_counter #(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_value;
        else if (enable)
            cnt <= cnt - 1'b1;
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/tempo_sequencer.sv
// tempo_sequencer: beat-timing FSM driving count-in and beat ticks from one countdown.
// Optional TEMPO_SEQ_METRONOME_EN stretches every tick into a 2^METRO_W-clock metro click.
module tempo_sequencer
    import tempo_pkg::*;
#(
    parameter int CNT_W         = 28,
    parameter int BEAT_W        = 10,
    parameter int COUNTIN_BEATS = 4,
    parameter int P0            = DEF_P0,
    parameter int P1            = DEF_P1,
    parameter int P2            = DEF_P2,
    parameter int P3            = DEF_P3
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic              start,
    input  logic              pause,
    input  logic              resume,
    input  logic              abort,
    input  logic [1:0]        difficulty,
    input  logic [BEAT_W-1:0] song_len,
    output logic              count_tick,
    output logic              beat_tick,
    output logic [BEAT_W-1:0] beat_index,
    output logic              running,
    output logic              paused,
    output logic              done,
    output logic              metro
);
    state_t            state, ret_state, nxt;
    logic [1:0]        diff_q, sel;
    logic [BEAT_W-1:0] len_q;
    logic [3:0]        cin;
    logic [CNT_W-1:0]  period_m1;
    logic              zero, active, accept, hold, tick, last_cin, last_beat;

    assign active     = state == COUNTIN || state == RUN;
    assign accept     = !abort && start && (state == IDLE || state == DONE);
    assign hold       = active && pause;
    // A pause landing on the zero cycle swallows the tick; the held zero replays it on resume.
    assign tick       = active && zero && !abort && !pause;
    assign count_tick = tick && state == COUNTIN;
    assign beat_tick  = tick && state == RUN;
    assign last_cin   = cin == 4'(COUNTIN_BEATS - 1);
    assign last_beat  = len_q != '0 && beat_index == len_q - 1'b1;
    assign sel        = accept ? difficulty : diff_q;
    assign period_m1  = sel == DIFF_INSANE ? CNT_W'(P0 - 1) :
                        sel == DIFF_NORMAL ? CNT_W'(P1 - 1) :
                        sel == DIFF_SLOWER ? CNT_W'(P2 - 1) : CNT_W'(P3 - 1);

    tick_counter #(.CNT_W(CNT_W)) u_counter (
        .clk        (clock),
        .rst        (reset_b),
        .load       (abort || accept || tick),
        .load_value (abort ? '0 : period_m1),
        .enable     (active && !pause),
        .zero       (zero)
    );

    always_comb begin
        nxt = abort                      ? IDLE      :
              accept                     ? COUNTIN   :
              hold                       ? PAUSED    :
              resume && state == PAUSED  ? ret_state :
              count_tick && last_cin     ? RUN       :
              beat_tick && last_beat     ? DONE      : state;
    end

    always_ff @(posedge clock or posedge reset_b) begin
        if (reset_b) begin
            state      <= IDLE;
            ret_state  <= IDLE;
            diff_q     <= '0;
            len_q      <= '0;
            cin        <= '0;
            beat_index <= '0;
            running    <= 1'b0;
            paused     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= nxt;
            running    <= nxt == COUNTIN || nxt == RUN;
            paused     <= nxt == PAUSED;
            done       <= nxt == DONE;
            ret_state  <= hold ? state : ret_state;
            diff_q     <= accept ? difficulty : diff_q;
            len_q      <= accept ? song_len : len_q;
            cin        <= abort || accept ? '0 : count_tick ? cin + 1'b1 : cin;
            beat_index <= abort || accept ? '0 : beat_tick ? beat_index + 1'b1 : beat_index;
        end
    end

`ifdef TEMPO_SEQ_METRONOME_EN
    logic [METRO_W-1:0] stretch;

    always_ff @(posedge clock or posedge reset_b) begin
        if (reset_b)
            stretch <= '0;
        else
            stretch <= abort ? '0 : tick ? '1 : stretch == '0 ? '0 : stretch - 1'b1;
    end

    assign metro = tick || stretch != '0;
`else
    assign metro = 1'b0;
`endif
endmodule

// File: tb/tb_tempo_sequencer.sv
// tb_tempo_sequencer: scoreboard bench for tempo_sequencer with short periods and a 2-bit beat index.
module tb_tempo_sequencer;
    typedef struct packed {
        logic [31:0] cyc;
        logic        beat;
        logic [1:0]  idx;
    } ev_t;

`ifdef TEMPO_SEQ_METRONOME_EN
    localparam logic METRO_EXP = 1'b1;
`else
    localparam logic METRO_EXP = 1'b0;
`endif

    logic       clock = 1'b0, reset_b = 1'b0;
    logic       start = 1'b0, pause = 1'b0, resume = 1'b0, abort = 1'b0;
    logic [1:0] difficulty = 2'b00, song_len = 2'b00;
    logic       count_tick, beat_tick, running, paused, done, metro;
    logic [1:0] beat_index;
    int         cyc = 0, checks = 0, failures = 0;
    ev_t        exp_q[$], obs_q[$];
    int         s_cyc;
    logic       s_run, s_pau, s_done, s_met;
    logic [1:0] s_bi;

    tempo_sequencer #(
        .CNT_W(8), .BEAT_W(2), .COUNTIN_BEATS(4), .P0(2), .P1(4), .P2(6), .P3(8)
    ) dut (
        .clock      (clock),
        .reset_b    (reset_b),
        .start      (start),
        .pause      (pause),
        .resume     (resume),
        .abort      (abort),
        .difficulty (difficulty),
        .song_len   (song_len),
        .count_tick (count_tick),
        .beat_tick  (beat_tick),
        .beat_index (beat_index),
        .running    (running),
        .paused     (paused),
        .done       (done),
        .metro      (metro)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Samples one period at its falling edge, logs ticks, then moves just past the next rising edge.
    task automatic step();
        @(negedge clock);
        s_cyc  = cyc;
        s_run  = running;
        s_pau  = paused;
        s_done = done;
        s_met  = metro;
        s_bi   = beat_index;
        if (count_tick) obs_q.push_back({32'(cyc), 1'b0, beat_index});
        if (beat_tick) obs_q.push_back({32'(cyc), 1'b1, beat_index});
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int c, input logic b, input logic [1:0] i);
        exp_q.push_back({32'(c), b, i});
    endtask

    task automatic begin_seq(input logic [1:0] d, input logic [1:0] len, output int k);
        difficulty = d;
        song_len   = len;
        start      = 1'b1;
        step();
        start      = 1'b0;
        k          = cyc;
    endtask

    task automatic test_reset();
        #1 reset_b = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({count_tick, beat_tick, beat_index, running, paused, done, metro} !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got %b expected 00000000",
                     {count_tick, beat_tick, beat_index, running, paused, done, metro});
        end
        @(negedge clock);
        reset_b = 1'b0;
        @(posedge clock);
        #1;
        repeat (6) step();
        checks++;
        if (s_run !== 1'b0 || obs_q.size() != 0) begin
            failures++;
            $display("FAIL reset_idle got running=%b ticks=%0d expected running=0 ticks=0", s_run, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_count_in_run();
        int k;
        ev_t e, o;
        logic er, ed;
        begin_seq(2'b01, 2'd3, k);
        push(k+3, 0, 0); push(k+7, 0, 0); push(k+11, 0, 0); push(k+15, 0, 0);
        push(k+19, 1, 0); push(k+23, 1, 1); push(k+27, 1, 2);
        repeat (31) begin
            step();
            er = s_cyc <= k + 27;
            ed = s_cyc >= k + 28;
            checks++;
            if (s_run !== er || s_done !== ed) begin
                failures++;
                $display("FAIL basic_flags at k+%0d got running=%b done=%b expected running=%b done=%b",
                         s_cyc - k, s_run, s_done, er, ed);
            end
            if (s_cyc == k + 4) begin
                checks++;
                if (s_met !== METRO_EXP) begin
                    failures++;
                    $display("FAIL basic_metro got %b expected %b", s_met, METRO_EXP);
                end
            end
        end
        checks++;
        if (beat_index !== 2'd3) begin
            failures++;
            $display("FAIL basic_final_index got %0d expected 3", beat_index);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL basic_tick got cyc=k+%0d beat=%b idx=%0d expected cyc=k+%0d beat=%b idx=%0d",
                         int'(o.cyc) - k, o.beat, o.idx, int'(e.cyc) - k, e.beat, e.idx);
            end
        end
    endtask

    task automatic test_pause_resume();
        int k;
        ev_t e, o;
        logic ep, ed;
        begin_seq(2'b01, 2'd3, k);
        push(k+3, 0, 0); push(k+13, 0, 0); push(k+17, 0, 0); push(k+21, 0, 0);
        push(k+25, 1, 0); push(k+29, 1, 1); push(k+33, 1, 2);
        for (int i = 0; i < 37; i++) begin
            pause  = cyc == k + 7;
            resume = cyc == k + 12;
            step();
            ep = s_cyc >= k + 8 && s_cyc <= k + 12;
            ed = s_cyc >= k + 34;
            checks++;
            if (s_pau !== ep || s_done !== ed) begin
                failures++;
                $display("FAIL pause_flags at k+%0d got paused=%b done=%b expected paused=%b done=%b",
                         s_cyc - k, s_pau, s_done, ep, ed);
            end
        end
        pause  = 1'b0;
        resume = 1'b0;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pause_tick got cyc=k+%0d beat=%b idx=%0d expected cyc=k+%0d beat=%b idx=%0d",
                         int'(o.cyc) - k, o.beat, o.idx, int'(e.cyc) - k, e.beat, e.idx);
            end
        end
    endtask

    task automatic test_endless_wrap();
        int k;
        ev_t e, o;
        logic [1:0] idx = 2'd0;
        begin_seq(2'b00, 2'd0, k);
        for (int c = 1; c <= 7; c += 2) push(k + c, 0, 0);
        for (int c = 9; c <= 19; c += 2) begin
            push(k + c, 1, idx);
            idx++;
        end
        for (int i = 0; i < 22; i++) begin
            abort = cyc == k + 21;
            step();
            checks++;
            if (s_done !== 1'b0) begin
                failures++;
                $display("FAIL endless_done at k+%0d got %b expected 0", s_cyc - k, s_done);
            end
        end
        abort = 1'b0;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL endless_tick got cyc=k+%0d beat=%b idx=%0d expected cyc=k+%0d beat=%b idx=%0d",
                         int'(o.cyc) - k, o.beat, o.idx, int'(e.cyc) - k, e.beat, e.idx);
            end
        end
    endtask

    task automatic test_abort();
        int k;
        ev_t e, o;
        begin_seq(2'b01, 2'd0, k);
        push(k+3, 0, 0); push(k+7, 0, 0); push(k+11, 0, 0); push(k+15, 0, 0);
        push(k+19, 1, 0);
        for (int i = 0; i < 41; i++) begin
            difficulty = cyc >= k + 13 ? 2'b00 : 2'b01;
            start      = cyc == k + 17;
            abort      = cyc == k + 21;
            step();
            if (s_cyc == k + 21) begin
                checks++;
                if (s_bi !== 2'd1 || s_run !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_before got index=%0d running=%b expected index=1 running=1", s_bi, s_run);
                end
            end
            if (s_cyc >= k + 22) begin
                checks++;
                if (s_bi !== 2'd0 || s_run !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_after at k+%0d got index=%0d running=%b expected index=0 running=0",
                             s_cyc - k, s_bi, s_run);
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL abort_tick got cyc=k+%0d beat=%b idx=%0d expected cyc=k+%0d beat=%b idx=%0d",
                         int'(o.cyc) - k, o.beat, o.idx, int'(e.cyc) - k, e.beat, e.idx);
            end
        end
    endtask

    task automatic test_async_reset();
        int k;
        ev_t e, o;
        begin_seq(2'b01, 2'd3, k);
        push(k+3, 0, 0);
        repeat (5) step();
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL async_pre got running=%b expected 1", running);
        end
        #2 reset_b = 1'b1;
        #1;
        checks++;
        if ({count_tick, beat_tick, beat_index, running, paused, done, metro} !== 8'd0) begin
            failures++;
            $display("FAIL async_outputs got %b expected 00000000",
                     {count_tick, beat_tick, beat_index, running, paused, done, metro});
        end
        @(negedge clock);
        reset_b = 1'b0;
        @(posedge clock);
        #1;
        repeat (12) begin
            step();
            checks++;
            if (s_run !== 1'b0) begin
                failures++;
                $display("FAIL async_idle at k+%0d got running=%b expected 0", s_cyc - k, s_run);
            end
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = '1; o = '1;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL async_tick got cyc=k+%0d beat=%b idx=%0d expected cyc=k+%0d beat=%b idx=%0d",
                         int'(o.cyc) - k, o.beat, o.idx, int'(e.cyc) - k, e.beat, e.idx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_in_run();
        test_pause_resume();
        test_endless_wrap();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected finish before time limit");
        $fatal(1);
    end
endmodule
